// File: rtl/debug_uart_tx.sv
// debug_uart_tx: 8N1 UART framer for the seven CPU debug ports; define DEBUG_TX_CHECKSUM_EN to append an XOR checksum byte
module debug_uart_tx #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;
`ifdef DEBUG_TX_CHECKSUM_EN
  localparam logic [3:0] LAST = 4'd8;
`else
  localparam logic [3:0] LAST = 4'd7;
`endif
  logic [1:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit_idx;
  logic [3:0]    r_byte_idx;
  logic [7:0]    r_shift;
  logic [55:0]   r_snap;
  logic          r_tx;
  logic          r_busy;
  logic          r_done;
  logic          w_bit_end;
  logic [63:0]   w_frame;
  logic [7:0]    w_next_byte;
  assign w_bit_end = r_timer == TW'(CLKS_PER_BIT - 1);
`ifdef DEBUG_TX_CHECKSUM_EN
  assign w_frame = {r_snap[7:0] ^ r_snap[15:8] ^ r_snap[23:16] ^ r_snap[31:24] ^
                    r_snap[39:32] ^ r_snap[47:40] ^ r_snap[55:48], r_snap};
`else
  assign w_frame = {8'h00, r_snap};
`endif
  // byte after frame position r_byte_idx: port bytes live at snapshot index r_byte_idx, checksum above them
  assign w_next_byte = w_frame[{r_byte_idx[2:0], 3'b000} +: 8];
  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;
  // tx is registered with the level of the bit that starts on this edge, so it changes exactly at bit boundaries
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_snap     <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_timer <= '0;
        if (start) begin
          r_snap     <= {debug_port7, debug_port6, debug_port5, debug_port4,
                         debug_port3, debug_port2, debug_port1};
          r_byte_idx <= '0;
          r_shift    <= SYNC_BYTE;
          r_state    <= S_START;
          r_tx       <= 1'b0;
          r_busy     <= 1'b1;
        end
      end else if (!w_bit_end) begin
        r_timer <= r_timer + TW'(1);
      end else begin
        r_timer <= '0;
        case (r_state)
          S_START: begin
            r_state   <= S_DATA;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
          end
          S_DATA: begin
            r_bit_idx <= r_bit_idx + 3'd1;
            r_state   <= (r_bit_idx == 3'd7) ? S_STOP : S_DATA;
            r_tx      <= (r_bit_idx == 3'd7) ? 1'b1 : r_shift[r_bit_idx + 3'd1];
          end
          default: begin
            if (r_byte_idx < LAST) begin
              r_byte_idx <= r_byte_idx + 4'd1;
              r_shift    <= w_next_byte;
              r_state    <= S_START;
              r_tx       <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: doc/debug_uart_tx.md
# debug_uart_tx

Serial transmitter for the CPU's seven 8-bit debug ports. It sits beside `cpu` and is the sending end of the serial-port debugger link. On a `start` request it snapshots `debug_port1`..`debug_port7` and frames them behind a sync byte. It shifts the frame out as 8N1 UART, LSB first, with a handshake so the CPU or a trigger counter can request a new frame.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Must be >= 2.
- `SYNC_BYTE`, default 8'hA5: first byte of every frame.

Ports:
- `clk` in 1: single clock; all state changes on posedge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: frame request, sampled only in IDLE.
- `debug_port1`..`debug_port7` in 8 each: payload bytes, captured on the accepting edge.
- `tx` out 1: UART line, idle high, registered.
- `busy` out 1: high while a frame is in flight.
- `done` out 1: one-cycle pulse at frame completion.

## Operation
- Frame order: SYNC_BYTE, then port1 … port7, then the optional checksum byte (see Configuration).
- Each byte is sent as 10 bits: start bit (0), data[0]..data[7], stop bit (1).
- Every bit is held for exactly CLKS_PER_BIT cycles.
- Snapshot: all seven ports are latched into a 7×8 register on the edge where `start` is accepted. Later changes to the ports do not affect the frame in flight.
- FSM states:
  - IDLE: `tx`=1, `busy`=0. `start`=1 latches the snapshot, clears byte_idx to 0, loads the shift register with SYNC_BYTE, and goes to START_BIT.
  - START_BIT: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA; bit_idx=0.
  - DATA: `tx`=shift[bit_idx] for CLKS_PER_BIT cycles each. After bit 7 go to STOP_BIT.
  - STOP_BIT: `tx`=1 for CLKS_PER_BIT cycles. Then, if byte_idx < LAST, increment byte_idx, load the next byte, and go to START_BIT. Otherwise go to IDLE and pulse `done`.
- LAST is 8 with the checksum enabled and 7 without it.
- Bit-timer width is $clog2(CLKS_PER_BIT). The bit timer counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- `start` while busy is ignored; it is not queued.
- `start` held high starts a new frame on the same edge `done` is high, since the FSM is in IDLE that cycle. This gives back-to-back frames with one extra idle-high cycle after the last stop bit.
- `reset` asserted mid-frame: on that edge go to IDLE with `tx`=1, `busy`=0, `done`=0. The frame is abandoned and no `done` is produced.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, FSM=IDLE, all counters 0, snapshot 0.
- Accepting edge T (`start`=1 in IDLE): from T+1, `tx`=0 and `busy`=1.
- Frame duration: N×10×CLKS_PER_BIT cycles of `busy`=1, with N=9 with checksum and N=8 without.
- `done`=1 in the single cycle after the last stop-bit cycle. In that cycle `busy`=0 and `tx`=1.
- `tx` is driven from a flop; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `DEBUG_TX_CHECKSUM_EN`.
- Defined: a ninth byte is appended, equal to port1^port2^…^port7 taken from the snapshot; SYNC is excluded. LAST=8 and N=9.
- Undefined: no checksum byte and no checksum logic. LAST=7 and N=8.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset check: hold `reset`=1 for 3 cycles, then release. Required: `tx`=1, `busy`=0, `done`=0, and no activity while `start`=0.
- Basic frame, ports 0x01..0x07, one-cycle `start`. Required:
  - decoded bytes A5,01,02,03,04,05,06,07,00 with the checksum enabled;
  - `busy` high for exactly 360 cycles (320 without the checksum);
  - a single `done` pulse.
- Snapshot stability: set ports {FF,00,00,00,00,00,01} and start, then change all ports to 0x55 ten cycles later. Required:
  - decoded payload FF,00,00,00,00,00,01;
  - checksum FE.
- Ignored start: pulse `start` at cycles 50 and 200 of a frame. Required: exactly one frame and one `done`, and `busy` never deasserts mid-frame.
- Reset mid-frame: assert `reset` in the DATA state of byte 3. Required:
  - next cycle `tx`=1, `busy`=0;
  - no `done`;
  - a subsequent `start` produces a complete, correct frame.
- Continuous `start`=1 for two frames. Required:
  - the second frame's start bit begins 1 cycle after the `done` pulse;
  - both frames decode correctly;
  - exactly two `done` pulses.
